fetch_prefetch_queue: RTL
=========================

// Module: fetch_prefetch_queue
// PURPOSE
//  Instruction-fetch front end, directly upstream of the IF/ID pipeline register.
//  Owns the fetch PC and issues sequential requests to instruction memory over a
//  valid/ready request channel with an in-order, variable-latency response channel.
//  Buffers returned {pc, instr} pairs in a DEPTH-entry queue that feeds IF/ID.
//  Honours hazard-unit stalls and flushes on taken-branch redirect from EX/MEM.
// PARAMETERS
//  XLEN      32            data/address width
//  DEPTH     4             queue entries; also max in-flight requests (power of 2, >=2)
//  RESET_PC  32'h0000_0000 first fetch address after reset
// PORTS
//  clk               in   1     single clock, all state on rising edge
//  reset             in   1     synchronous, active-high
//  i_stall           in   1     1 = IF/ID not accepting (hazard unit IFIDWrite deasserted)
//  i_redirect        in   1     taken branch: flush, restart fetch at i_redirect_pc
//  i_redirect_pc     in   XLEN  branch target; bits [1:0] forced to 0 internally
//  o_imem_req_valid  out  1     request to instruction memory
//  i_imem_req_ready  in   1     memory accepts request this cycle
//  o_imem_addr       out  XLEN  request address (= fetch PC)
//  i_imem_rsp_valid  in   1     response word valid, returned in request order
//  i_imem_rsp_data   in   XLEN  instruction word
//  o_valid           out  1     queue head valid toward IF/ID
//  o_pc              out  XLEN  PC of head instruction
//  o_instr           out  XLEN  head instruction; NOP (32'h0000_0013) when !o_valid
// BEHAVIOUR
//  Reset (sync, dominates all inputs): pc=RESET_PC, queue empty, out_cnt=0,
//   drop_cnt=0; outputs: o_valid=0, o_pc=0, o_instr=NOP, o_imem_req_valid=0.
//  State: pc, queue count cnt (0..DEPTH), out_cnt (in-flight, 0..DEPTH),
//   drop_cnt (stale in-flight, <= out_cnt).
//  Request: o_imem_req_valid = !i_redirect && (cnt + out_cnt < DEPTH); o_imem_addr = pc.
//   Accept (valid&&ready): pc += 4 (mod 2^XLEN wrap), out_cnt += 1.
//   Once raised, valid holds with a stable address until accepted, unless a redirect occurs.
//  Response: out_cnt -= 1. drop_cnt>0 -> discard, drop_cnt -= 1;
//   else push {pc_of_req, data}. The in-order request PC is kept in a shadow
//   PC FIFO of depth DEPTH. Credit rule guarantees push never overflows.
//  Pop: o_valid && !i_stall && !i_redirect. Push and pop in the same cycle -> cnt unchanged.
//  Outputs o_valid/o_pc/o_instr are combinational from the queue head (registered storage).
//  Latency: 1-cycle memory, always ready -> first o_valid 2 cycles after reset
//   deasserts; steady state 1 instr/cycle with DEPTH>=2.
//  Redirect (highest priority after reset): next cycle pc=i_redirect_pc&~3, queue
//   and PC FIFO emptied, no pop, no request this cycle,
//   drop_cnt <= out_cnt - i_imem_rsp_valid (a response arriving in the redirect
//   cycle is itself dropped). Applies even while i_stall=1.
//  Back-to-back redirects: each recomputes drop_cnt; the last target wins.
//  Stall with full queue: requests stop (credit), no data lost, outputs stable.
//  i_imem_rsp_valid with out_cnt==0: ignored; simulation assertion fires.
//  Reset mid-flight: all counters cleared; in-flight responses after reset must
//   not occur (memory is reset by the same reset).
// STRUCTURE
//  Package fetch_pkg: XLEN, NOP_INSTR=32'h0000_0013, typedef struct packed
//   {logic [XLEN-1:0] pc; logic [XLEN-1:0] instr;} fetch_entry_t.
//  One sub-module: sync_fifo (parameterised width/depth, push/pop/flush, count);
//   instantiated for the entry queue and for the in-flight PC FIFO.
//  Top: pc register, out_cnt/drop_cnt counters, credit and redirect logic.
// TESTING
//  1 Reset release, 1-cycle mem, no stall -> addrs 0,4,8,...; o_valid at cycle 2; o_pc 0,4,8 consecutive.
//  2 i_stall=1 for 10 cycles -> cnt reaches DEPTH=4, req_valid=0, o_pc held at 0; release -> 0,4,8,12,16 in order.
//  3 3-cycle mem latency, 3 in flight, redirect to 0x100 -> 3 stale words dropped; next o_valid has o_pc=0x100.
//  4 Redirect cycle coincides with response -> that response dropped, drop_cnt=out_cnt-1; no wrong-path instr at output.
//  5 i_imem_req_ready low 5 cycles -> o_imem_addr stable, held valid; pc advances only on accept.
//  6 Redirect to 0x102 -> fetch at 0x100; reset asserted mid-stall -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- presented to IF/ID whenever no real instruction is available
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // One fetched instruction together with the address it was fetched from
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_queue_sync_fifo.sv
// Small synchronous FIFO with push, pop, flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
// A push into a full FIFO is ignored unless a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_pushData,
  input  logic                         i_pop,
  input  logic                         i_flush,
  output logic [WIDTH-1:0]             o_headData,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;

  logic w_empty;
  logic w_full;
  logic w_doPush;
  logic w_doPop;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_doPop  = i_pop && !w_empty;
  assign w_doPush = i_push && (!w_full || w_doPop);

  // Storage array: written on an accepted push, never reset
  always_ff @(posedge clk) begin
    if (w_doPush && !i_flush) begin
      r_mem[r_wrPtr] <= i_pushData;
    end
  end

  // Pointers and count: flush empties the FIFO and wins over push/pop
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      if (w_doPush && !w_doPop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_doPush && w_doPop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  assign o_headData = r_mem[r_rdPtr];
  assign o_count    = r_count;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues sequential requests
// to instruction memory under a credit limit, and buffers returned
// {pc, instr} pairs for IF/ID. Taken-branch redirects flush the queue and
// mark every outstanding request as stale so its response is discarded.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_imem_req_valid,
  input  logic            i_imem_req_ready,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_rsp_valid,
  input  logic [XLEN-1:0] i_imem_rsp_data,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_instr
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_outCnt;
  logic [CW-1:0]   r_dropCnt;

  logic [CW-1:0]   w_qCount;
  logic [CW-1:0]   w_pcCount;
  logic [CW:0]     w_used;
  logic            w_hasCredit;
  logic            w_accept;
  logic            w_rspAccepted;
  logic            w_dropRsp;
  logic            w_keepRsp;
  logic            w_pop;
  logic [CW-1:0]   w_outCntNext;
  logic [XLEN-1:0] w_pcHead;
  logic [XLEN-1:0] w_redirectTarget;
  fetch_entry_t    w_pushEntry;
  fetch_entry_t    w_head;

  // Every slot is either buffered or promised to an outstanding request, so
  // a returning response always has room in the queue.
  assign w_used      = {1'b0, w_qCount} + {1'b0, r_outCnt};
  assign w_hasCredit = (w_used < (CW + 1)'(DEPTH));

  assign o_imem_req_valid = !reset && !i_redirect && w_hasCredit;
  assign o_imem_addr      = r_pc;
  assign w_accept         = o_imem_req_valid && i_imem_req_ready;

  // A response with nothing outstanding is ignored entirely
  assign w_rspAccepted = i_imem_rsp_valid && (r_outCnt != '0);
  assign w_dropRsp     = w_rspAccepted && (r_dropCnt != '0);
  assign w_keepRsp     = w_rspAccepted && (r_dropCnt == '0) && !i_redirect;

  assign w_pop = o_valid && !i_stall && !i_redirect;

  assign w_redirectTarget = i_redirect_pc & ~XLEN'(3);
  assign w_pushEntry      = '{pc: w_pcHead, instr: i_imem_rsp_data};

  // Addresses of live (non-stale) requests in issue order
  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pcFifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_accept),
    .i_pushData (r_pc),
    .i_pop      (w_keepRsp),
    .i_flush    (i_redirect),
    .o_headData (w_pcHead),
    .o_count    (w_pcCount)
  );

  // Fetched instructions waiting for IF/ID
  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_entryQueue (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_keepRsp),
    .i_pushData (w_pushEntry),
    .i_pop      (w_pop),
    .i_flush    (i_redirect),
    .o_headData (w_head),
    .o_count    (w_qCount)
  );

  // Fetch PC: jump on redirect, otherwise advance one word per accepted request
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (i_redirect) begin
      r_pc <= w_redirectTarget;
    end else if (w_accept) begin
      r_pc <= r_pc + XLEN'(4);
    end
  end

  // Outstanding-request count after this cycle's accept and response
  always_comb begin
    w_outCntNext = r_outCnt;
    if (w_accept && !w_rspAccepted) begin
      w_outCntNext = r_outCnt + CW'(1);
    end else if (!w_accept && w_rspAccepted) begin
      w_outCntNext = r_outCnt - CW'(1);
    end
  end

  // In-flight and stale counters; a redirect marks every request still
  // outstanding after this cycle as stale
  always_ff @(posedge clk) begin
    if (reset) begin
      r_outCnt  <= '0;
      r_dropCnt <= '0;
    end else begin
      r_outCnt <= w_outCntNext;
      if (i_redirect) begin
        r_dropCnt <= r_outCnt - CW'(w_rspAccepted);
      end else if (w_dropRsp) begin
        r_dropCnt <= r_dropCnt - CW'(1);
      end
    end
  end

  // Head of the queue toward IF/ID, NOP and zero PC when empty
  always_comb begin
    o_valid = (w_qCount != '0);
    o_pc    = '0;
    o_instr = NOP_INSTR;
    if (o_valid) begin
      o_pc    = w_head.pc;
      o_instr = w_head.instr;
    end
  end

  // Memory must never answer a request that was not made
  assert property (@(posedge clk) disable iff (reset)
                   !(i_imem_rsp_valid && (r_outCnt == '0)));

  // Live PCs can never outnumber outstanding requests
  assert property (@(posedge clk) disable iff (reset)
                   (w_pcCount <= r_outCnt));

endmodule
